aftab_store_align_unit: RTL

Store-side counterpart of the AFTAB load sign-extension path: takes a byte/half/word store request from the datapath and drives it onto the 32-bit word-addressed data memory port. It shifts the data and generates byte enables. Misaligned halfword and word stores are split into two aligned write beats. It sits between the datapath store controls and the data-memory write interface, with a ready/valid-style handshake on the memory side.

---
 rtl/aftab_store_align_unit_if.sv | 33 +++
 rtl/aftab_store_align_unit.sv | 106 ++++++++++
 2 files changed

// File: rtl/aftab_store_align_unit_if.sv
// Store request / data-memory write bundle for aftab_store_align_unit.
// slave is the align unit; master is the datapath/memory side.
interface aftab_store_align_unit_if #(
    parameter int size = 32
);
    logic            start;
    logic            storeByte;
    logic            storeHalf;
    logic            storeWord;
    logic [size-1:0] addrIn;
    logic [size-1:0] dataIn;
    logic            memReady;
    logic [size-1:0] memAddr;
    logic [size-1:0] memDataOut;
    logic [3:0]      memByteEn;
    logic            memWrite;
    logic            busy;
    logic            done;

    modport slave (
        input  start, storeByte, storeHalf, storeWord,
        input  addrIn, dataIn, memReady,
        output memAddr, memDataOut, memByteEn,
        output memWrite, busy, done
    );

    modport master (
        output start, storeByte, storeHalf, storeWord,
        output addrIn, dataIn, memReady,
        input  memAddr, memDataOut, memByteEn,
        input  memWrite, busy, done
    );
endinterface

// File: rtl/aftab_store_align_unit.sv
// Store alignment: lane-shifts byte/half/word stores onto a word port,
// splitting misaligned accesses into two aligned write beats.
module aftab_store_align_unit #(
    parameter int size = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    aftab_store_align_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        BEAT1,
        BEAT2,
        DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [size-1:0]   r_base;
    logic [7:0]        r_be8;
    logic [2*size-1:0] r_d64;

    logic              w_sel;
    logic              w_accept;
    logic [3:0]        w_mask;
    logic [size-1:0]   w_data;
    logic [7:0]        w_be8;
    logic [2*size-1:0] w_d64;

    assign w_sel = bus.storeByte | bus.storeHalf | bus.storeWord;
    assign w_accept = (r_state == IDLE) && bus.start && w_sel;

    // Byte wins over half, half over word; data above the width is dropped.
    always_comb begin
        w_mask = 4'b1111;
        w_data = bus.dataIn;
        if (bus.storeByte) begin
            w_mask = 4'b0001;
            w_data = {{(size-8){1'b0}}, bus.dataIn[7:0]};
        end else if (bus.storeHalf) begin
            w_mask = 4'b0011;
            w_data = {{(size-16){1'b0}}, bus.dataIn[15:0]};
        end
    end

    assign w_be8 = {4'b0000, w_mask} << bus.addrIn[1:0];
    assign w_d64 = {{size{1'b0}}, w_data} << {bus.addrIn[1:0], 3'b000};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_base  <= '0;
            r_be8   <= '0;
            r_d64   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_base <= {bus.addrIn[size-1:2], 2'b00};
                r_be8  <= w_be8;
                r_d64  <= w_d64;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (w_accept) w_next = BEAT1;
            BEAT1: begin
                if (bus.memReady)
                    w_next = (|r_be8[7:4]) ? BEAT2 : DONE;
            end
            BEAT2: if (bus.memReady) w_next = DONE;
            DONE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs depend only on registered state and latched request.
    always_comb begin
        bus.memAddr    = '0;
        bus.memDataOut = '0;
        bus.memByteEn  = 4'b0000;
        bus.memWrite   = 1'b0;
        case (r_state)
            BEAT1: begin
                bus.memAddr    = r_base;
                bus.memDataOut = r_d64[size-1:0];
                bus.memByteEn  = r_be8[3:0];
                bus.memWrite   = 1'b1;
            end
            BEAT2: begin
                bus.memAddr    = r_base + size'(4);
                bus.memDataOut = r_d64[2*size-1:size];
                bus.memByteEn  = r_be8[7:4];
                bus.memWrite   = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.busy = (r_state != IDLE);
    assign bus.done = (r_state == DONE);

endmodule
